// File: rtl/load_store_unit.sv
// RV32I memory-access stage: turns load/store requests into req/ack bus cycles,
// steers byte lanes, extends load data and flags misaligned, illegal and timed-out accesses.
module load_store_unit #(
    parameter int NB_WORD        = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic               i_clock,
    input  logic               i_reset_n,
    input  logic               i_dmem_rd,
    input  logic               i_dmem_wr,
    input  logic [2:0]         i_ld_st_funct3,
    input  logic [NB_WORD-1:0] i_addr,
    input  logic [NB_WORD-1:0] i_store_data,
    output logic               o_stall,
    output logic [NB_WORD-1:0] o_load_data,
    output logic               o_load_valid,
    output logic               o_fault,
    output logic               o_bus_err,
    output logic               o_mem_req,
    output logic               o_mem_we,
    output logic [NB_WORD-1:0] o_mem_addr,
    output logic [3:0]         o_mem_be,
    output logic [NB_WORD-1:0] o_mem_wdata,
    input  logic               i_mem_ack,
    input  logic [NB_WORD-1:0] i_mem_rdata
);

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam int                 TIMER_W    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic {
        ST_IDLE,
        ST_BUSY
    } state_t;

    state_t state_q, state_d;

    // Latched access, held stable on the bus for the whole BUSY phase.
    logic [NB_WORD-1:0] addr_q;
    logic [2:0]         funct3_q;
    logic               we_q;
    logic [3:0]         be_q;
    logic [NB_WORD-1:0] wdata_q;
    logic [TIMER_W-1:0] timer_q, timer_d;

    logic [NB_WORD-1:0] load_data_q;
    logic               load_valid_q;
    logic               fault_q;
    logic               bus_err_q;

    // Request decode
    logic               req_any;
    logic               req_load;
    logic               funct3_ok;
    logic               aligned;
    logic               req_ok;
    logic               req_bad;
    logic [3:0]         req_be;
    logic [NB_WORD-1:0] req_wdata;

    // FSM strobes
    logic capture;
    logic ack_done;
    logic timeout;

    // NOTE: every signal written in an always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        req_any   = i_dmem_rd | i_dmem_wr;
        req_load  = i_dmem_rd;
        funct3_ok = 1'b0;
        aligned   = 1'b1;
        req_be    = 4'b0000;
        req_wdata = '0;

        if (req_load) begin
            funct3_ok = i_ld_st_funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
        end else begin
            funct3_ok = i_ld_st_funct3 inside {F3_B, F3_H, F3_W};
        end

        case (i_ld_st_funct3)
            F3_H, F3_HU: aligned = ~i_addr[0];
            F3_W:        aligned = (i_addr[1:0] == 2'b00);
            default:     aligned = 1'b1;
        endcase

        // Loads always fetch the whole word; lane selection happens on return.
        if (req_load) begin
            req_be = 4'b1111;
        end else begin
            case (i_ld_st_funct3)
                F3_B: begin
                    req_be    = 4'b0001 << i_addr[1:0];
                    req_wdata = {4{i_store_data[7:0]}};
                end
                F3_H: begin
                    req_be    = i_addr[1] ? 4'b1100 : 4'b0011;
                    req_wdata = {2{i_store_data[15:0]}};
                end
                default: begin
                    req_be    = 4'b1111;
                    req_wdata = i_store_data;
                end
            endcase
        end

        req_ok  = req_any & funct3_ok & aligned;
        req_bad = req_any & ~(funct3_ok & aligned);
    end

    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        capture  = 1'b0;
        ack_done = 1'b0;
        timeout  = 1'b0;
        o_stall  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req_ok) begin
                    o_stall = 1'b1;
                    capture = 1'b1;
                    timer_d = '0;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                o_stall = 1'b1;
                if (i_mem_ack) begin
                    ack_done = 1'b1;
                    timer_d  = '0;
                    state_d  = ST_IDLE;
                end else if (timer_q == TIMER_LAST) begin
                    timeout = 1'b1;
                    timer_d = '0;
                    state_d = ST_IDLE;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Lane selection and extension of the returned word, using the latched access.
    function automatic logic [NB_WORD-1:0] extend_load(
        input logic [2:0]         funct3,
        input logic [1:0]         lane,
        input logic [NB_WORD-1:0] rdata
    );
        logic [7:0]  sel_byte;
        logic [15:0] sel_half;
        sel_byte = rdata[{lane, 3'b000} +: 8];
        sel_half = rdata[{lane[1], 4'b0000} +: 16];
        case (funct3)
            F3_B:    extend_load = {{(NB_WORD-8){sel_byte[7]}}, sel_byte};
            F3_H:    extend_load = {{(NB_WORD-16){sel_half[15]}}, sel_half};
            F3_BU:   extend_load = {{(NB_WORD-8){1'b0}}, sel_byte};
            F3_HU:   extend_load = {{(NB_WORD-16){1'b0}}, sel_half};
            default: extend_load = rdata;
        endcase
    endfunction

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= ST_IDLE;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
        end
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            addr_q   <= '0;
            funct3_q <= 3'b000;
            we_q     <= 1'b0;
            be_q     <= 4'b0000;
            wdata_q  <= '0;
        end else if (capture) begin
            addr_q   <= i_addr;
            funct3_q <= i_ld_st_funct3;
            we_q     <= ~req_load;
            be_q     <= req_be;
            wdata_q  <= req_wdata;
        end
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            load_data_q  <= '0;
            load_valid_q <= 1'b0;
            fault_q      <= 1'b0;
            bus_err_q    <= 1'b0;
        end else begin
            load_valid_q <= ack_done & ~we_q;
            fault_q      <= (state_q == ST_IDLE) & req_bad;
            bus_err_q    <= timeout;
            if (ack_done && !we_q) begin
                load_data_q <= extend_load(funct3_q, addr_q[1:0], i_mem_rdata);
            end
        end
    end

    // Bus qualifiers are forced low outside BUSY so an idle bus never shows a write.
    always_comb begin
        o_mem_req   = (state_q == ST_BUSY);
        o_mem_we    = o_mem_req & we_q;
        o_mem_be    = o_mem_req ? be_q : 4'b0000;
        o_mem_addr  = {addr_q[NB_WORD-1:2], 2'b00};
        o_mem_wdata = wdata_q;
    end

    assign o_load_data  = load_data_q;
    assign o_load_valid = load_valid_q;
    assign o_fault      = fault_q;
    assign o_bus_err    = bus_err_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: bus cycles, lane steering, load extension,
// fault and timeout pulses, back-to-back accesses and mid-access reset.
module tb_load_store_unit;

    logic        i_clock;
    logic        i_reset_n;
    logic        i_dmem_rd;
    logic        i_dmem_wr;
    logic [2:0]  i_ld_st_funct3;
    logic [31:0] i_addr;
    logic [31:0] i_store_data;
    logic        o_stall;
    logic [31:0] o_load_data;
    logic        o_load_valid;
    logic        o_fault;
    logic        o_bus_err;
    logic        o_mem_req;
    logic        o_mem_we;
    logic [31:0] o_mem_addr;
    logic [3:0]  o_mem_be;
    logic [31:0] o_mem_wdata;
    logic        i_mem_ack;
    logic [31:0] i_mem_rdata;

    int checks   = 0;
    int failures = 0;

    // Expected load results, pushed at issue and popped on each valid pulse.
    logic [31:0] sb_q[$];

    load_store_unit #(.NB_WORD(32), .TIMEOUT_CYCLES(16)) dut (
        .i_clock        (i_clock),
        .i_reset_n      (i_reset_n),
        .i_dmem_rd      (i_dmem_rd),
        .i_dmem_wr      (i_dmem_wr),
        .i_ld_st_funct3 (i_ld_st_funct3),
        .i_addr         (i_addr),
        .i_store_data   (i_store_data),
        .o_stall        (o_stall),
        .o_load_data    (o_load_data),
        .o_load_valid   (o_load_valid),
        .o_fault        (o_fault),
        .o_bus_err      (o_bus_err),
        .o_mem_req      (o_mem_req),
        .o_mem_we       (o_mem_we),
        .o_mem_addr     (o_mem_addr),
        .o_mem_be       (o_mem_be),
        .o_mem_wdata    (o_mem_wdata),
        .i_mem_ack      (i_mem_ack),
        .i_mem_rdata    (i_mem_rdata)
    );

    initial i_clock = 1'b0;
    always #5 i_clock = ~i_clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge i_clock);
        #1;
    endtask

    task automatic clear_req();
        i_dmem_rd      = 1'b0;
        i_dmem_wr      = 1'b0;
        i_ld_st_funct3 = 3'b000;
        i_addr         = '0;
        i_store_data   = '0;
    endtask

    // Issues one legal access in the current cycle, acks it in BUSY cycle ack_delay,
    // and returns in the cycle after the ack so a new request may follow at once.
    task automatic do_access(
        input string       tag,
        input logic        rd,
        input logic        wr,
        input logic [2:0]  f3,
        input logic [31:0] addr,
        input logic [31:0] data,
        input int          ack_delay,
        input logic [31:0] rdata,
        input logic [3:0]  exp_be,
        input logic [31:0] exp_wdata,
        input logic [31:0] exp_load
    );
        int stall_cnt;
        i_dmem_rd      = rd;
        i_dmem_wr      = wr;
        i_ld_st_funct3 = f3;
        i_addr         = addr;
        i_store_data   = data;
        if (rd) sb_q.push_back(exp_load);
        @(negedge i_clock);
        check({tag, " issue_stall"}, 32'(o_stall), 32'd1);
        check({tag, " issue_noreq"}, 32'(o_mem_req), 32'd0);
        stall_cnt = 1;
        next_cycle();
        clear_req();
        for (int i = 1; i <= ack_delay; i++) begin
            if (i == ack_delay) begin
                i_mem_ack   = 1'b1;
                i_mem_rdata = rdata;
            end
            @(negedge i_clock);
            check({tag, " busy_req"}, 32'(o_mem_req), 32'd1);
            check({tag, " busy_addr"}, o_mem_addr, {addr[31:2], 2'b00});
            check({tag, " busy_be"}, 32'(o_mem_be), 32'(exp_be));
            check({tag, " busy_we"}, 32'(o_mem_we), 32'(!rd));
            if (!rd) check({tag, " busy_wdata"}, o_mem_wdata, exp_wdata);
            if (o_stall) stall_cnt++;
            next_cycle();
            i_mem_ack   = 1'b0;
            i_mem_rdata = '0;
        end
        #1;
        check({tag, " done_stall"}, 32'(o_stall), 32'd0);
        check({tag, " done_req"}, 32'(o_mem_req), 32'd0);
        check({tag, " done_be"}, 32'(o_mem_be), 32'd0);
        check({tag, " done_we"}, 32'(o_mem_we), 32'd0);
        check({tag, " stall_cycles"}, 32'(stall_cnt), 32'(ack_delay + 1));
        check({tag, " load_valid"}, 32'(o_load_valid), 32'(rd));
        if (o_load_valid) begin
            if (sb_q.size() == 0) begin
                check({tag, " sb_nonempty"}, 32'd0, 32'd1);
            end else begin
                check({tag, " load_data"}, o_load_data, sb_q.pop_front());
            end
        end
    endtask

    // An illegal or misaligned request must never reach the bus nor stall.
    task automatic do_fault(
        input string       tag,
        input logic        rd,
        input logic        wr,
        input logic [2:0]  f3,
        input logic [31:0] addr
    );
        i_dmem_rd      = rd;
        i_dmem_wr      = wr;
        i_ld_st_funct3 = f3;
        i_addr         = addr;
        i_store_data   = 32'h1234_5678;
        @(negedge i_clock);
        check({tag, " stall"}, 32'(o_stall), 32'd0);
        check({tag, " req"}, 32'(o_mem_req), 32'd0);
        next_cycle();
        clear_req();
        @(negedge i_clock);
        check({tag, " fault_pulse"}, 32'(o_fault), 32'd1);
        check({tag, " req_after"}, 32'(o_mem_req), 32'd0);
        check({tag, " stall_after"}, 32'(o_stall), 32'd0);
        next_cycle();
        check({tag, " fault_clear"}, 32'(o_fault), 32'd0);
    endtask

    initial begin
        int          busy_cnt;
        logic [31:0] held;

        i_reset_n   = 1'b0;
        i_mem_ack   = 1'b0;
        i_mem_rdata = '0;
        clear_req();

        // Reset state
        repeat (2) @(negedge i_clock);
        check("rst stall", 32'(o_stall), 32'd0);
        check("rst req", 32'(o_mem_req), 32'd0);
        check("rst we", 32'(o_mem_we), 32'd0);
        check("rst be", 32'(o_mem_be), 32'd0);
        check("rst addr", o_mem_addr, 32'd0);
        check("rst wdata", o_mem_wdata, 32'd0);
        check("rst load_data", o_load_data, 32'd0);
        check("rst load_valid", 32'(o_load_valid), 32'd0);
        check("rst fault", 32'(o_fault), 32'd0);
        check("rst bus_err", 32'(o_bus_err), 32'd0);
        next_cycle();
        i_reset_n = 1'b1;
        next_cycle();

        // LB of the top byte 0x80 sign-extends; ack in third BUSY cycle -> 4 stall cycles
        do_access("lb", 1'b1, 1'b0, 3'b000, 32'h0000_0103, 32'h0, 3,
                  32'h80FF_1234, 4'b1111, 32'h0, 32'hFFFF_FF80);
        next_cycle();
        check("lb valid_once", 32'(o_load_valid), 32'd0);
        check("lb data_hold", o_load_data, 32'hFFFF_FF80);

        // SH to upper half: lanes 3:2, replicated halfword, no load pulse
        do_access("sh", 1'b0, 1'b1, 3'b001, 32'h0000_0202, 32'h0000_ABCD, 1,
                  32'h0, 4'b1100, 32'hABCD_ABCD, 32'h0);
        check("sh data_hold", o_load_data, 32'hFFFF_FF80);

        // SB to lane 2
        do_access("sb", 1'b0, 1'b1, 3'b000, 32'h0000_0102, 32'hFFFF_FF5A, 2,
                  32'h0, 4'b0100, 32'h5A5A_5A5A, 32'h0);

        // Halfword and unsigned-byte loads from various lanes
        do_access("lhu", 1'b1, 1'b0, 3'b101, 32'h0000_0006, 32'h0, 1,
                  32'h8001_7FFE, 4'b1111, 32'h0, 32'h0000_8001);
        do_access("lh", 1'b1, 1'b0, 3'b001, 32'h0000_0004, 32'h0, 1,
                  32'h8001_F00D, 4'b1111, 32'h0, 32'hFFFF_F00D);
        do_access("lbu", 1'b1, 1'b0, 3'b100, 32'h0000_0011, 32'h0, 2,
                  32'h0000_F500, 4'b1111, 32'h0, 32'h0000_00F5);

        // rd and wr both high: treated as a load
        do_access("rdwr", 1'b1, 1'b1, 3'b010, 32'h0000_0020, 32'hDEAD_DEAD, 1,
                  32'h0BAD_CAFE, 4'b1111, 32'h0, 32'h0BAD_CAFE);

        // Faults: misaligned LW, illegal load funct3, illegal store funct3, misaligned SH
        do_fault("lw_misal", 1'b1, 1'b0, 3'b010, 32'h0000_0101);
        do_fault("ld_f3_011", 1'b1, 1'b0, 3'b011, 32'h0000_0100);
        do_fault("st_f3_100", 1'b0, 1'b1, 3'b100, 32'h0000_0100);
        do_fault("sh_misal", 1'b0, 1'b1, 3'b001, 32'h0000_0103);

        // LHU that never gets an ack: bus error after exactly 16 BUSY cycles
        i_dmem_rd      = 1'b1;
        i_ld_st_funct3 = 3'b101;
        i_addr         = 32'h0000_0002;
        @(negedge i_clock);
        check("tmo issue_stall", 32'(o_stall), 32'd1);
        next_cycle();
        clear_req();
        busy_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge i_clock);
            if (!o_mem_req) break;
            busy_cnt++;
            next_cycle();
        end
        check("tmo busy_cycles", 32'(busy_cnt), 32'd16);
        check("tmo bus_err", 32'(o_bus_err), 32'd1);
        check("tmo load_valid", 32'(o_load_valid), 32'd0);
        check("tmo stall", 32'(o_stall), 32'd0);
        next_cycle();
        check("tmo bus_err_clear", 32'(o_bus_err), 32'd0);

        // Back-to-back LW: second issued in the cycle right after the first ack
        do_access("lw0", 1'b1, 1'b0, 3'b010, 32'h0000_0400, 32'h0, 2,
                  32'h1122_3344, 4'b1111, 32'h0, 32'h1122_3344);
        do_access("lw1", 1'b1, 1'b0, 3'b010, 32'h0000_0404, 32'h0, 1,
                  32'hCAFE_F00D, 4'b1111, 32'h0, 32'hCAFE_F00D);
        held = 32'hCAFE_F00D;
        next_cycle();
        check("lw1 data_hold", o_load_data, held);

        // Reset during BUSY drops the bus request without waiting for a clock edge
        i_dmem_wr      = 1'b1;
        i_ld_st_funct3 = 3'b010;
        i_addr         = 32'h0000_0300;
        i_store_data   = 32'h5555_AAAA;
        next_cycle();
        clear_req();
        @(negedge i_clock);
        check("rstbusy req_before", 32'(o_mem_req), 32'd1);
        #2;
        i_reset_n = 1'b0;
        #1;
        check("rstbusy req", 32'(o_mem_req), 32'd0);
        check("rstbusy stall", 32'(o_stall), 32'd0);
        check("rstbusy be", 32'(o_mem_be), 32'd0);
        next_cycle();
        i_reset_n = 1'b1;
        next_cycle();
        do_access("sw_post", 1'b0, 1'b1, 3'b010, 32'h0000_0304, 32'h1234_5678, 2,
                  32'h0, 4'b1111, 32'h1234_5678, 32'h0);

        check("sb empty", 32'(sb_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
